// File: rtl/bcd_binary.sv
// Converts three BCD digits to an 8-bit binary value by reverse double-dabble, one bit per clock.
// Latency: done pulses 10 cycles after an accepted start for valid input, 2 cycles for invalid input.
// No backpressure: start is only taken in IDLE; starts during a conversion are dropped, not queued.
module bcd_binary (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] hundreds,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   output logic [7:0] binary,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  count;
   logic [11:0] bcd;
   logic [7:0]  sr;
   logic        errf;
   logic        invalid;
   logic [19:0] shifted;
   logic [11:0] bcd_adj;

   // Digits >= 8 after a right shift held a carried-in half-ten; removing 3 restores valid BCD.
   function automatic logic [3:0] adj(input logic [3:0] d);
      return (d >= 4'd8) ? (d - 4'd3) : d;
   endfunction

   // Range check on the raw port digits: any non-BCD digit or a value above 255.
   always_comb begin
      invalid = (hundreds > 4'd9) || (tens > 4'd9) || (ones > 4'd9) ||
                (hundreds > 4'd2) ||
                ((hundreds == 4'd2) && (tens > 4'd5)) ||
                ((hundreds == 4'd2) && (tens == 4'd5) && (ones > 4'd5));
   end

   // One reverse double-dabble step: shift the BCD/result pair right, then correct each digit.
   always_comb begin
      shifted = {bcd, sr} >> 1;
      bcd_adj = {adj(shifted[19:16]), adj(shifted[15:12]), adj(shifted[11:8])};
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = invalid ? DONE : SHIFT;
         SHIFT:   if (count == 3'd7) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 3'd0;
         bcd    <= 12'd0;
         sr     <= 8'd0;
         errf   <= 1'b0;
         binary <= 8'd0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  bcd   <= {hundreds, tens, ones};
                  sr    <= 8'd0;
                  count <= 3'd0;
                  busy  <= 1'b1;
                  errf  <= invalid;
               end
            end
            SHIFT: begin
               bcd   <= bcd_adj;
               sr    <= shifted[7:0];
               count <= count + 3'd1;
            end
            DONE: begin
               binary <= errf ? 8'd0 : sr;
               err    <= errf;
               done   <= 1'b1;
               busy   <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_binary.sv
// Bench for bcd_binary: directed scenarios plus a full valid sweep and random digits,
// checked against a decimal-arithmetic reference model.
module tb_bcd_binary;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] hundreds;
   logic [3:0] tens;
   logic [3:0] ones;
   logic [7:0] binary;
   logic       busy;
   logic       done;
   logic       err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd_binary dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .hundreds (hundreds),
      .tens     (tens),
      .ones     (ones),
      .binary   (binary),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain decimal value, rejected if any digit is not BCD or the value exceeds a byte.
   function automatic void ref_conv(input int h, input int t, input int o,
                                    output int b, output int e);
      int v;
      v = 100 * h + 10 * t + o;
      e = (h > 9 || t > 9 || o > 9 || v > 255) ? 1 : 0;
      b = e ? 0 : v;
   endfunction

   // Waits (bounded) for done, starting just after the accepting edge; n counts negedges seen.
   task automatic wait_done(input int prev, output int n, output int busy_ok, output int hold_ok);
      n = 0;
      busy_ok = 1;
      hold_ok = 1;
      while (n < 30) begin
         @(negedge clk);
         n++;
         if (done) break;
         if (busy !== 1'b1) busy_ok = 0;
         if (binary !== prev[7:0]) hold_ok = 0;
      end
   endtask

   task automatic run_one(input int h, input int t, input int o, input string tag);
      int b, e, n, bok, hok, prev;
      prev = int'(binary);
      hundreds = h[3:0];
      tens     = t[3:0];
      ones     = o[3:0];
      start    = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(prev, n, bok, hok);
      ref_conv(h, t, o, b, e);
      chk({tag, "_done"},  int'(done), 1);
      chk({tag, "_lat"},   n - 1, e ? 1 : 9);
      chk({tag, "_bin"},   int'(binary), b);
      chk({tag, "_err"},   int'(err), e);
      chk({tag, "_busy0"}, int'(busy), 0);
      chk({tag, "_busy1"}, bok, 1);
      chk({tag, "_hold"},  hok, 1);
      @(negedge clk);
      chk({tag, "_width"}, int'(done), 0);
   endtask

   initial begin
      int n, bok, hok, prev, extra, pulses, first, last, stable_ok;
      int h, t, o;

      rst = 1'b1;
      start = 1'b0;
      hundreds = 4'd0;
      tens = 4'd0;
      ones = 4'd0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_bin",  int'(binary), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err",  int'(err), 0);

      run_one(2, 5, 5, "max");
      run_one(2, 5, 6, "inv256");
      run_one(3, 0, 0, "inv300");
      run_one(0, 10, 0, "invdig");

      // Full sweep of every valid value.
      for (int v = 0; v < 256; v++) begin
         run_one(v / 100, (v / 10) % 10, v % 10, "sweep");
      end

      // A second start during the conversion must be ignored.
      prev = int'(binary);
      hundreds = 4'd1; tens = 4'd2; ones = 4'd8;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      hundreds = 4'd0; tens = 4'd0; ones = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(prev, n, bok, hok);
      chk("ign_done", int'(done), 1);
      chk("ign_lat",  n + 3 - 1, 9);
      chk("ign_bin",  int'(binary), 128);
      chk("ign_err",  int'(err), 0);
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("ign_extra", extra, 0);

      // Reset in the middle of SHIFT aborts the conversion.
      hundreds = 4'd0; tens = 4'd9; ones = 4'd9;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      extra = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("abort_done", extra, 0);
      chk("abort_bin",  int'(binary), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_err",  int'(err), 0);
      run_one(0, 4, 2, "after_abort");

      // Random digits, mostly in range with some out-of-range digits mixed in.
      for (int i = 0; i < 150; i++) begin
         h = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
         t = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
         o = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
         run_one(h, t, o, "rand");
      end

      // start held high: back-to-back conversions every 10 cycles.
      prev = int'(binary);
      hundreds = 4'd0; tens = 4'd0; ones = 4'd7;
      start = 1'b1;
      pulses = 0;
      first = 0;
      last = 0;
      stable_ok = 1;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         if (done) begin
            if (pulses == 0) first = c;
            else chk("hold_period", c - last, 10);
            last = c;
            pulses++;
            chk("hold_err", int'(err), 0);
         end
         if (pulses > 0 && binary !== 8'd7) stable_ok = 0;
         if (pulses == 0 && binary !== prev[7:0]) stable_ok = 0;
      end
      chk("hold_first",  first, 10);
      chk("hold_pulses", pulses, 4);
      chk("hold_stable", stable_ok, 1);
      start = 1'b0;
      repeat (12) @(negedge clk);
      chk("idle_busy", int'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bcd_binary.md
Name: bcd_binary

Overview:
Sequential 3-digit BCD to 8-bit binary converter: the inverse of the display-side binary-to-BCD path. Used where decimal entry (switch or keypad digits) must be turned into an 8-bit operand for the CPU datapath. Implements reverse double-dabble (shift right, subtract 3 from any digit >= 8), one bit per clock, with a start/busy/done handshake and range checking of the input.

Parameters:
None. Widths are fixed: 3 BCD digits in, 8 bits out.

Ports:
clk       input   1  system clock; all state changes on the rising edge
rst       input   1  synchronous reset, active-high
start     input   1  request conversion; sampled only in IDLE
hundreds  input   4  BCD hundreds digit; sampled on the accepted start edge
tens      input   4  BCD tens digit; sampled on the accepted start edge
ones      input   4  BCD ones digit; sampled on the accepted start edge
binary    output  8  result; held stable from done until the next accepted start completes
busy      output  1  high while a conversion is in progress (SHIFT or DONE state)
done      output  1  one-cycle pulse marking binary and err as valid
err       output  1  result-valid qualifier: 1 means the input was invalid; held with binary

Behaviour:
- Reset (rst=1 at a rising edge): state goes to IDLE, count=0. Internal BCD and shift registers go to 0. Outputs: binary=0, busy=0, done=0, err=0. Reset has priority over every other event.
- States: IDLE, SHIFT, DONE.
- IDLE, start=0: no action. Outputs hold their last result; done=0.
- IDLE, start=1 (edge k): latch {hundreds,tens,ones} into a 12-bit BCD register. Clear the 8-bit shift register and count. Set busy=1.
  - Validation is combinational on the port values at edge k.
  - Invalid if any digit > 9, or the value > 255: hundreds > 2; or hundreds=2 and tens > 5; or hundreds=2, tens=5 and ones > 5.
  - Invalid: err_next=1, state goes to DONE.
  - Valid: err_next=0, state goes to SHIFT.
- SHIFT, once per edge, for 8 edges (count 0..7):
  - Shift {bcd[11:0], sr[7:0]} right by 1 as one 20-bit register, so bcd[0] enters sr[7].
  - Then, for each 4-bit digit of the shifted BCD register, subtract 3 if the digit is >= 8. This is 4-bit arithmetic; no borrow crosses digits.
  - count increments each edge. When count=7, go to DONE.
- DONE (one edge): binary <= sr (or 8'h00 if the error flag is set); err <= error flag; done <= 1; busy <= 0; state goes to IDLE.
- Latency, start sampled at edge k:
  - Valid input: done=1 in the cycle after edge k+9.
  - Invalid input: done=1 in the cycle after edge k+1.
- done is high for exactly one cycle. busy is high from after edge k until the edge that raises done.
- start while busy=1 is ignored; no queueing. The digit inputs are don't-care while busy.
- Back-to-back: start may be high in the cycle where done=1 (state is already IDLE). It is accepted, and binary/err keep the previous result until the new done.
- rst during SHIFT or DONE aborts the conversion: no done pulse, outputs cleared as for reset.
- done, busy, err and binary are all registered outputs; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with 2,5,5 -> busy=1 for 9 cycles, then done pulse with binary=8'hFF, err=0. Check done is exactly 1 cycle wide.
- Sweep every valid input from 0,0,0 to 2,5,5, one start after each done -> binary equals 100*h+10*t+o for all 256 values; err=0; latency is 9 every time.
- Input 2,5,6, then 3,0,0, then 0,10,0 (tens=4'hA) -> each gives a done pulse 1 cycle after start with err=1 and binary=8'h00.
- Start with 1,2,8; pulse start again and change the digits to 0,0,1 during busy -> single done with binary=8'h80. The second start is ignored.
- Start with 0,9,9; assert rst at the 4th SHIFT cycle -> no done pulse; binary=0, busy=0, err=0. A following start with 0,4,2 gives binary=8'h2A.
- Hold start=1 continuously with 0,0,7 -> done pulses every 10 cycles with binary=8'h07. binary stays stable between pulses.
